dll_tx_replay_buf: RTL

- Data Link Layer transmit stage between the Transaction Layer and dll_tx_tlp.
- Assigns a 12-bit sequence number to each outgoing 128-bit TLP and forwards it downstream.
- Holds a copy of every TLP until an ACK DLLP covers it.
- On a NAK, replays all unacknowledged TLPs in order.

---
 rtl/dll_tx_replay_buf.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dll_tx_replay_buf.sv
// DLL transmit replay buffer: tags outgoing TLPs with sequence numbers, retains
// them until ACKed, and replays every unacknowledged TLP in order after a NAK.
module dll_tx_replay_buf #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               dlc_state_i,
    input  logic [127:0]             tl_tlp_i,
    input  logic                     tl_tlp_valid_i,
    output logic                     tl_tlp_ready_o,
    input  logic                     ack_valid_i,
    input  logic                     ack_nak_i,
    input  logic [SEQ_W-1:0]         ack_seq_i,
    output logic [127:0]             tlp_o,
    output logic                     tlp_valid_o,
    output logic [SEQ_W-1:0]         seq_o,
    output logic                     replay_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     ack_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_NORMAL = 2'd1;
    localparam logic [1:0] S_REPLAY = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    wr_ptr, rd_ptr, rp_ptr;
    logic [SEQ_W-1:0] next_seq, ackd_seq;
    logic [127:0]     mem_data [DEPTH];
    logic [SEQ_W-1:0] mem_seq  [DEPTH];

    logic             active;
    logic [PW-1:0]    occ;
    logic [SEQ_W-1:0] ack_d;
    logic             ack_take, ack_bad;
    logic [PW-1:0]    purge, new_rd, remain, rp_cur, rp_nxt;
    logic             accept;

    assign active         = (dlc_state_i == 2'b11);
    assign occ            = wr_ptr - rd_ptr;
    assign occupancy_o    = occ;
    assign replay_o       = (state == S_REPLAY);
    assign tl_tlp_ready_o = (state == S_NORMAL) && (occ < PW'(DEPTH));
    assign accept         = tl_tlp_valid_i && tl_tlp_ready_o;

    // Range check is against the pre-accept occupancy, so a TLP accepted in the
    // same cycle can never be purged by the DLLP arriving alongside it.
    always_comb begin
        ack_d    = ack_seq_i - ackd_seq;
        ack_take = ack_valid_i && (ack_d <= SEQ_W'(occ));
        ack_bad  = ack_valid_i && !(ack_d <= SEQ_W'(occ));
        purge    = ack_take ? PW'(ack_d) : '0;
        new_rd   = rd_ptr + purge;
        remain   = wr_ptr - new_rd;
        // A NAK restarts replay; an ACK only moves the replay pointer if it
        // was left pointing into the purged region.
        if ((ack_take && ack_nak_i) || ((rp_ptr - rd_ptr) < purge))
            rp_cur = new_rd;
        else
            rp_cur = rp_ptr;
        rp_nxt = rp_cur + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wr_ptr[AW-1:0]] <= tl_tlp_i;
            mem_seq[wr_ptr[AW-1:0]]  <= next_seq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rp_ptr      <= '0;
            next_seq    <= '0;
            ackd_seq    <= '1;
            tlp_o       <= '0;
            seq_o       <= '0;
            tlp_valid_o <= 1'b0;
            ack_err_o   <= 1'b0;
        end else begin
            tlp_o       <= '0;
            seq_o       <= '0;
            tlp_valid_o <= 1'b0;
            ack_err_o   <= 1'b0;
            if (!active) begin
                state    <= S_IDLE;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                rp_ptr   <= '0;
                next_seq <= '0;
                ackd_seq <= '1;
            end else begin
                case (state)
                    S_IDLE: state <= S_NORMAL;
                    S_NORMAL: begin
                        ack_err_o <= ack_bad;
                        if (ack_take) begin
                            rd_ptr   <= new_rd;
                            ackd_seq <= ack_seq_i;
                        end
                        if (accept) begin
                            wr_ptr      <= wr_ptr + PW'(1);
                            next_seq    <= next_seq + 1'b1;
                            tlp_o       <= tl_tlp_i;
                            seq_o       <= next_seq;
                            tlp_valid_o <= 1'b1;
                        end
                        if (ack_take && ack_nak_i && (remain != '0)) begin
                            state  <= S_REPLAY;
                            rp_ptr <= new_rd;
                        end
                    end
                    S_REPLAY: begin
                        ack_err_o <= ack_bad;
                        if (ack_take) begin
                            rd_ptr   <= new_rd;
                            ackd_seq <= ack_seq_i;
                        end
                        if (remain == '0) begin
                            state <= S_NORMAL;
                        end else begin
                            tlp_o       <= mem_data[rp_cur[AW-1:0]];
                            seq_o       <= mem_seq[rp_cur[AW-1:0]];
                            tlp_valid_o <= 1'b1;
                            rp_ptr      <= rp_nxt;
                            if (rp_nxt == wr_ptr)
                                state <= S_NORMAL;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
